stall_ctrl: RTL



---
 rtl/stall_ctrl_pkg.sv | 8 +
 rtl/stall_ctrl_div.sv | 38 +++
 rtl/stall_ctrl.sv | 59 +++++
 3 files changed

// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared divider state encodings and constants for the stall controller
package stall_ctrl_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int DIV_CYCLES_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/stall_ctrl_div.sv
// div_seq: divider occupancy FSM with down-counter; freezes EX for DIV_CYCLES cycles then pulses done
module div_seq
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_div_stall,
  output logic o_div_busy,
  output logic o_div_done
);
  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 2);
  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic w_idle;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_RUN;
          r_cnt   <= CNT_INIT;
        end
        S_RUN: if (r_cnt == 8'd0) r_state <= S_DONE;
               else r_cnt <= r_cnt - 8'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  assign w_idle      = r_state == S_IDLE;
  // the IDLE cycle that accepts the start already counts as the first stalled cycle
  assign o_div_stall = rst_n & ((r_state == S_RUN) | (w_idle & i_start));
  assign o_div_busy  = o_div_stall;
  assign o_div_done  = rst_n & (r_state == S_DONE);
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: load-use/divide stall and branch flush control with saturating stall-cycle counter
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_raddr1,
  input  logic [4:0]       id_raddr2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             id_branch_taken,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic             ex_div_start,
  input  logic [4:0]       mem_waddr,
  input  logic             mem_reg_wr,
  input  logic             mem_mem_rd,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);
  logic w_ex_ld, w_mem_ld, w_m1, w_m2, w_lu, w_div_stall;
  logic [CNT_W-1:0] r_stall_cycles;
  div_seq #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (ex_div_start),
    .o_div_stall(w_div_stall),
    .o_div_busy (div_busy),
    .o_div_done (div_done)
  );
  // WB needs no check: the regfile writes through to the same-cycle read
  assign w_ex_ld  = ex_reg_wr & ex_mem_rd;
  assign w_mem_ld = mem_reg_wr & mem_mem_rd;
  assign w_m1 = id_re1 & (id_raddr1 != REG_ZERO) &
                ((w_ex_ld & (ex_waddr == id_raddr1)) | (w_mem_ld & (mem_waddr == id_raddr1)));
  assign w_m2 = id_re2 & (id_raddr2 != REG_ZERO) &
                ((w_ex_ld & (ex_waddr == id_raddr2)) | (w_mem_ld & (mem_waddr == id_raddr2)));
  assign w_lu       = rst_n & (w_m1 | w_m2);
  assign stall_pc   = w_div_stall | w_lu;
  assign stall_ifid = stall_pc;
  assign stall_idex = w_div_stall;
  assign flush_idex = w_lu & ~w_div_stall;
  // a stalled branch may hold stale operands, so its decision waits for the stall to clear
  assign flush_ifid = rst_n & id_branch_taken & ~stall_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stall_cycles <= '0;
    else if (stall_pc && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
  assign stall_cycles = r_stall_cycles;
endmodule
